// File: rtl/sram_pkg.sv
// Shared definitions for the masked, pipelined single-port SRAM model:
// init sequencer states, lane-count helper and the read-latency ceiling.
package sram_pkg;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } init_state_e;

  localparam int MAX_READ_LATENCY = 4;

  // Number of write-mask lanes in a word.
  function automatic int lane_count(input int bits, input int gran);
    return bits / gran;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: valid + data shift register of DEPTH stages.
// DEPTH = 0 is a pure feed-through. Valids are reset, data is not.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int BITS  = 80,
  parameter int DEPTH = 0
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            vld_i,
  input  logic [BITS-1:0] data_i,
  output logic            vld_o,
  output logic [BITS-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RSTB;
    assign vld_o  = vld_i;
    assign data_o = data_i;
  end else begin : g_shift
    logic [DEPTH-1:0] vld_q;
    logic [BITS-1:0]  data_q [DEPTH];

    // Shift the valid bits; a reset drops every read in flight.
    always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= vld_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Shift the data words alongside their valids.
    always_ff @(posedge CLK) begin
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];
  end

endmodule

// File: rtl/sram_sp_mask_pipe.sv
// Behavioural single-port SRAM with per-lane write mask, configurable read
// latency with a QV strobe, held read data and an optional post-reset
// zero-fill sequencer.
// Build option: define SRAM_RAND_OUT_EN to drive Q with random data on every
// cycle without QV; otherwise Q holds its last read value.
module sram_sp_mask_pipe
  import sram_pkg::*;
#(
  parameter int BITS          = 80,
  parameter int WORD_DEPTH    = 256,
  parameter int ADD_WIDTH     = $clog2(WORD_DEPTH),
  parameter int MASK_GRAN     = 8,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                                   CLK,
  input  logic                                   RSTB,
  input  logic                                   CEB,
  input  logic                                   WEB,
  input  logic [lane_count(BITS, MASK_GRAN)-1:0] BWEB,
  input  logic [ADD_WIDTH-1:0]                   A,
  input  logic [BITS-1:0]                        D,
  output logic [BITS-1:0]                        Q,
  output logic                                   QV,
  output logic                                   INIT_DONE
);

  localparam int LANES = lane_count(BITS, MASK_GRAN);
  // Out-of-range latencies are clamped into 1..MAX_READ_LATENCY.
  localparam int RL = (READ_LATENCY < 1) ? 1 :
                      (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                      READ_LATENCY;

  init_state_e          state_q, state_d;
  logic [ADD_WIDTH-1:0] cnt_q, cnt_d;
  logic                 init_done;
  logic                 init_we;
  logic                 acc;
  logic                 in_range;
  logic                 wr_en;
  logic                 rd_en;
  logic [BITS-1:0]      rd_data;
  logic                 pipe_vld;
  logic [BITS-1:0]      pipe_data;
  logic [BITS-1:0]      q_q;
  logic                 qv_q;
  logic [BITS-1:0]      mem [WORD_DEPTH];

`ifdef SRAM_RAND_OUT_EN
  // Fresh random word, 32-bit chunks stacked up and truncated to BITS.
  function automatic logic [BITS-1:0] rand_word();
    logic [BITS-1:0] w;
    w = '0;
    repeat ((BITS + 31) / 32) begin
      w = (w << 32) | BITS'({$random});
    end
    return w;
  endfunction
`endif

  // Init sequencer state and zero-fill address counter.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= (INIT_ON_RESET != 0) ? S_INIT : S_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk every address once, then settle in READY until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADD_WIDTH'(WORD_DEPTH - 1)) begin
        state_d = S_READY;
      end
    end
  end

  // Sequencer outputs: array usable flag and zero-fill write strobe.
  always_comb begin
    init_done = (state_q == S_READY);
    init_we   = (state_q == S_INIT);
  end

  // Access decode; reads beyond the array return zero, writes there vanish.
  always_comb begin
    acc      = init_done & ~CEB;
    in_range = (32'(A) < 32'(WORD_DEPTH));
    wr_en    = acc & ~WEB & in_range;
    rd_en    = acc & WEB;
    rd_data  = '0;
    if (in_range) begin
      rd_data = mem[A];
    end
  end

  // Array update: zero-fill during init, masked lane writes afterwards.
  always_ff @(posedge CLK) begin
    if (init_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (!BWEB[i]) begin
          mem[A][i*MASK_GRAN +: MASK_GRAN] <= D[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // The output register supplies the last latency stage.
  sram_rd_pipe #(
    .BITS  (BITS),
    .DEPTH (RL - 1)
  ) u_rd_pipe (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .vld_i  (rd_en),
    .data_i (rd_data),
    .vld_o  (pipe_vld),
    .data_o (pipe_data)
  );

  // Output register: QV is a one-cycle pulse, Q keeps the last read word.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      qv_q <= 1'b0;
      q_q  <= '0;
    end else begin
      qv_q <= pipe_vld;
      if (pipe_vld) begin
        q_q <= pipe_data;
      end
`ifdef SRAM_RAND_OUT_EN
      else begin
        q_q <= rand_word();
      end
`endif
    end
  end

  assign Q         = q_q;
  assign QV        = qv_q;
  assign INIT_DONE = init_done;

endmodule

// File: tb/tb_sram_sp_mask_pipe.sv
// Bench for sram_sp_mask_pipe: two instances share one stimulus stream,
// A = 256 words / latency 1, B = 200 words / latency 3.
module tb_sram_sp_mask_pipe;

  localparam int BITS  = 80;
  localparam int LANES = 10;
  localparam int AW    = 8;

  logic             CLK  = 1'b0;
  logic             RSTB = 1'b1;
  logic             CEB  = 1'b1;
  logic             WEB  = 1'b1;
  logic [LANES-1:0] BWEB = '1;
  logic [AW-1:0]    A    = '0;
  logic [BITS-1:0]  D    = '0;

  logic [BITS-1:0]  q_a, q_b;
  logic             qv_a, qv_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sram_sp_mask_pipe dut_a (
    .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .D(D),
    .Q(q_a), .QV(qv_a), .INIT_DONE(done_a)
  );

  sram_sp_mask_pipe #(.WORD_DEPTH(200), .READ_LATENCY(3)) dut_b (
    .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .D(D),
    .Q(q_b), .QV(qv_b), .INIT_DONE(done_b)
  );

  // Reference model: memory image per instance plus a time-stamped list of
  // pending read results.
  typedef struct {
    int              id;
    int              due;
    logic [BITS-1:0] data;
  } rd_t;

  rd_t             rq[$];
  logic [BITS-1:0] mm [2][256];
  int              wd  [2] = '{256, 200};
  int              lat [2] = '{1, 3};
  int              rel    = 0;
  int              edge_n = 0;
  logic [BITS-1:0] eq [2];
  logic            ev [2];

  task automatic model_reset();
    rq.delete();
    rel = 0;
    for (int d = 0; d < 2; d++) begin
      eq[d] = '0;
      ev[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    rd_t e;
    if (!RSTB) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        ev[d] = 1'b0;
        if (rel < wd[d]) begin
          mm[d][rel] = '0;
        end else if (!CEB) begin
          if (!WEB) begin
            if (int'(A) < wd[d]) begin
              for (int l = 0; l < LANES; l++) begin
                if (!BWEB[l]) mm[d][A][l*8 +: 8] = D[l*8 +: 8];
              end
            end
          end else begin
            e.id   = d;
            e.due  = edge_n + lat[d] - 1;
            e.data = (int'(A) < wd[d]) ? mm[d][A] : '0;
            rq.push_back(e);
          end
        end
      end
      for (int i = rq.size() - 1; i >= 0; i--) begin
        if (rq[i].due == edge_n) begin
          ev[rq[i].id] = 1'b1;
          eq[rq[i].id] = rq[i].data;
          rq.delete(i);
        end
      end
      rel++;
    end
    edge_n++;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = '1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BITS-1:0] d, input logic [LANES-1:0] m);
    CEB = 1'b0; WEB = 1'b0; A = a; D = d; BWEB = m;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    CEB = 1'b0; WEB = 1'b1; A = a;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    #2 RSTB = 1'b0;
    model_reset();
    repeat (3) cyc();
    checks++; if (q_a !== '0)     begin errors++; $display("FAIL reset_q_a got %h exp 0", q_a); end
    checks++; if (q_b !== '0)     begin errors++; $display("FAIL reset_q_b got %h exp 0", q_b); end
    checks++; if (qv_a !== 1'b0)  begin errors++; $display("FAIL reset_qv_a got %b exp 0", qv_a); end
    checks++; if (qv_b !== 1'b0)  begin errors++; $display("FAIL reset_qv_b got %b exp 0", qv_b); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b exp 0", done_a); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b got %b exp 0", done_b); end
  endtask

  // Release reset with a read held on 0x3F; init must take exactly the depth.
  task automatic test_init();
    RSTB = 1'b1;
    CEB = 1'b0; WEB = 1'b1; A = 8'h3F;
    for (int i = 1; i <= 257; i++) begin
      cyc();
      checks++; if (done_a !== (i >= 256)) begin errors++; $display("FAIL init_done_a cyc %0d got %b exp %b", i, done_a, (i >= 256)); end
      checks++; if (done_b !== (i >= 200)) begin errors++; $display("FAIL init_done_b cyc %0d got %b exp %b", i, done_b, (i >= 200)); end
      checks++; if (qv_a !== (i == 257))   begin errors++; $display("FAIL init_qv_a cyc %0d got %b exp %b", i, qv_a, (i == 257)); end
      checks++; if (qv_b !== ev[1])        begin errors++; $display("FAIL init_qv_b cyc %0d got %b exp %b", i, qv_b, ev[1]); end
    end
    checks++; if (q_a !== '0) begin errors++; $display("FAIL first_read_q_a got %h exp 0", q_a); end
    idle();
    repeat (3) cyc();
  endtask

  task automatic test_mask();
    logic [BITS-1:0] exp;
    exp = {{72{1'b1}}, 8'h00};
    wr(8'h10, '1, '0);
    wr(8'h10, '0, 10'b11_1111_1110);
    rd(8'h10);
    checks++; if (qv_a !== 1'b1) begin errors++; $display("FAIL mask_qv_a got %b exp 1", qv_a); end
    checks++; if (q_a !== exp)   begin errors++; $display("FAIL mask_q_a got %h exp %h", q_a, exp); end
    cyc();
    checks++; if (qv_b !== 1'b0) begin errors++; $display("FAIL mask_qv_b_early got %b exp 0", qv_b); end
    cyc();
    checks++; if (qv_b !== 1'b1) begin errors++; $display("FAIL mask_qv_b got %b exp 1", qv_b); end
    checks++; if (q_b !== exp)   begin errors++; $display("FAIL mask_q_b got %h exp %h", q_b, exp); end
  endtask

  task automatic test_back_to_back();
    logic [BITS-1:0] vals [3];
    logic            eqv;
    vals[0] = 80'hA; vals[1] = 80'hB; vals[2] = 80'hC;
    wr(8'd1, vals[0], '0);
    wr(8'd2, vals[1], '0);
    wr(8'd3, vals[2], '0);
    for (int k = 1; k <= 7; k++) begin
      if (k <= 3) begin
        CEB = 1'b0; WEB = 1'b1; A = AW'(k);
      end else begin
        idle();
      end
      cyc();
      eqv = (k <= 3);
      checks++; if (qv_a !== eqv) begin errors++; $display("FAIL b2b_qv_a k %0d got %b exp %b", k, qv_a, eqv); end
      checks++; if (q_a !== vals[(k <= 3) ? k-1 : 2]) begin errors++; $display("FAIL b2b_q_a k %0d got %h exp %h", k, q_a, vals[(k <= 3) ? k-1 : 2]); end
      eqv = (k >= 3 && k <= 5);
      checks++; if (qv_b !== eqv) begin errors++; $display("FAIL b2b_qv_b k %0d got %b exp %b", k, qv_b, eqv); end
      if (k >= 3) begin
        checks++; if (q_b !== vals[(k <= 5) ? k-3 : 2]) begin errors++; $display("FAIL b2b_q_b k %0d got %h exp %h", k, q_b, vals[(k <= 5) ? k-3 : 2]); end
      end
    end
  endtask

  task automatic test_wr_then_rd();
    wr(8'd7, 80'h55, '0);
    rd(8'd7);
    checks++; if (q_a !== 80'h55 || qv_a !== 1'b1) begin errors++; $display("FAIL wr_rd_a got %h/%b exp 55/1", q_a, qv_a); end
    repeat (2) cyc();
    checks++; if (q_b !== 80'h55 || qv_b !== 1'b1) begin errors++; $display("FAIL wr_rd_b got %h/%b exp 55/1", q_b, qv_b); end
  endtask

  task automatic test_out_of_range();
    logic [BITS-1:0] p, r;
    p = {$urandom, $urandom, 16'h1234};
    r = {16'hBEEF, $urandom, $urandom};
    wr(8'd199, p, '0);
    wr(8'd199, ~p, '1);
    wr(8'd210, r, '0);
    rd(8'd210);
    checks++; if (q_a !== r) begin errors++; $display("FAIL oor_a_210 got %h exp %h", q_a, r); end
    repeat (2) cyc();
    checks++; if (q_b !== '0 || qv_b !== 1'b1) begin errors++; $display("FAIL oor_b_210 got %h/%b exp 0/1", q_b, qv_b); end
    rd(8'd199);
    checks++; if (q_a !== p) begin errors++; $display("FAIL oor_a_199 got %h exp %h", q_a, p); end
    repeat (2) cyc();
    checks++; if (q_b !== p || qv_b !== 1'b1) begin errors++; $display("FAIL oor_b_199 got %h/%b exp %h/1", q_b, qv_b, p); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      CEB  = ($urandom_range(0, 3) == 0);
      WEB  = $urandom_range(0, 1);
      BWEB = LANES'($urandom);
      A    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(195, 255)) : AW'($urandom_range(0, 15));
      D    = {$urandom, $urandom, $urandom};
      cyc();
      checks++; if (qv_a !== ev[0]) begin errors++; $display("FAIL rand_qv_a n %0d got %b exp %b", n, qv_a, ev[0]); end
      checks++; if (q_a !== eq[0])  begin errors++; $display("FAIL rand_q_a n %0d got %h exp %h", n, q_a, eq[0]); end
      checks++; if (qv_b !== ev[1]) begin errors++; $display("FAIL rand_qv_b n %0d got %b exp %b", n, qv_b, ev[1]); end
      checks++; if (q_b !== eq[1])  begin errors++; $display("FAIL rand_q_b n %0d got %h exp %h", n, q_b, eq[1]); end
    end
    idle();
    repeat (4) cyc();
  endtask

  task automatic test_reset_midflight();
    rd(8'h10);
    #2 RSTB = 1'b0;
    model_reset();
    #1;
    checks++; if (qv_b !== 1'b0)   begin errors++; $display("FAIL mid_qv_b got %b exp 0", qv_b); end
    checks++; if (q_b !== '0)      begin errors++; $display("FAIL mid_q_b got %h exp 0", q_b); end
    checks++; if (q_a !== '0)      begin errors++; $display("FAIL mid_q_a got %h exp 0", q_a); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL mid_done_b got %b exp 0", done_b); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (qv_b !== 1'b0) begin errors++; $display("FAIL mid_hold_qv_b k %0d got %b exp 0", k, qv_b); end
    end
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_mask();
    test_back_to_back();
    test_wr_then_rd();
    test_out_of_range();
    test_random();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_sp_mask_pipe.md
Name: sram_sp_mask_pipe

Overview:
- Parametrised behavioural single-port SRAM model; successor to the fixed 256x80 macro model.
- Adds per-lane write mask, configurable read latency with a data-valid strobe, held read data, and optional post-reset zero-initialisation sequencer.
- Drop-in for cache/TLB data arrays in simulation and FPGA builds.

Parameters:
- BITS, 80, data word width.
- WORD_DEPTH, 256, number of words.
- ADD_WIDTH, $clog2(WORD_DEPTH), address width (derived, overridable).
- MASK_GRAN, 8, bits per write-mask lane; BITS must be a multiple of it.
- READ_LATENCY, 1, cycles from read accept to Q/QV; legal range 1..4.
- INIT_ON_RESET, 1, when 1 the array is zero-filled after reset.

Ports:
- CLK  input  1  clock; all state on rising edge.
- RSTB  input  1  asynchronous active-low reset.
- CEB  input  1  chip enable, active-low.
- WEB  input  1  write enable, active-low (0 = write, 1 = read).
- BWEB  input  BITS/MASK_GRAN  per-lane write mask, active-low (0 = write that lane).
- A  input  ADD_WIDTH  word address.
- D  input  BITS  write data.
- Q  output  BITS  read data.
- QV  output  1  Q carries data of a read completing this cycle.
- INIT_DONE  output  1  array usable; accesses accepted only while 1.

Behaviour:
- Reset (RSTB=0, async): Q=0, QV=0, read pipeline valids cleared, init address counter=0, INIT_DONE=0 if INIT_ON_RESET else 1. Array contents not reset.
- FSM (INIT_ON_RESET=1): INIT -> READY.
  - INIT: each cycle writes zero to ram[cnt]; cnt increments. After cnt=WORD_DEPTH-1 is written, next state READY and INIT_DONE=1. INIT lasts exactly WORD_DEPTH cycles after RSTB deasserts.
  - READY is terminal until the next reset.
- With INIT_ON_RESET=0 the FSM stays in READY and INIT_DONE=1 out of reset.
- While INIT_DONE=0: CEB/WEB/A/D/BWEB are ignored, no pipeline entry is made, QV=0.
- Write (INIT_DONE & !CEB & !WEB): for each lane i with BWEB[i]=0, ram[A] lane i <= D lane i. Other lanes are unchanged. All-ones BWEB is a legal no-op write. No QV is generated.
- Read (INIT_DONE & !CEB & WEB): ram[A] is sampled at that edge. Q/QV appear exactly READ_LATENCY edges later; QV is a 1-cycle pulse per read.
- Back-to-back reads give one QV per cycle, in order.
- Write to address X, then read X next cycle: the read returns the new data.
- Q holds its last valid value on non-QV cycles.
- Address >= WORD_DEPTH (non-power-of-2 depth):
  - Write is dropped.
  - Read returns all-zero with QV=1.
- Reset mid-operation: in-flight reads are discarded (no QV). Init restarts at address 0.

Optional Feature:
- Macro SRAM_RAND_OUT_EN.
  - Defined: on every cycle with QV=0, Q takes a fresh random value ({$random} replicated/truncated to BITS), matching real macro output uncertainty. Reset value of Q is still 0.
  - Undefined: Q holds, as above.

Decomposition:
- Shared package sram_pkg:
  - init FSM state enum (S_INIT, S_READY).
  - localparam helper for lane count, BITS/MASK_GRAN.
  - max READ_LATENCY constant (4).
- One sub-module: sram_rd_pipe, a parametrised valid+data shift register of depth READ_LATENCY-1 carrying sampled read data to Q/QV.

Test Plan:
- Defaults (WORD_DEPTH=256, INIT_ON_RESET=1); release RSTB, hold CEB=0/WEB=1 -> INIT_DONE rises exactly 256 cycles later, no QV before it. First read of A=0x3F returns 0 with QV one cycle later.
- Write A=0x10, D=80'hFFFF...F, BWEB=all-0. Then write D=0, BWEB=10'b11_1111_1110. Then read 0x10 -> Q=80'hFFFF...F00 with QV pulse.
- READ_LATENCY=3: reads of A=1,2,3 on consecutive cycles, data 0xA,0xB,0xC -> QV high on cycles 3,4,5 after the first read, Q=0xA,0xB,0xC; Q holds 0xC afterwards (macro undefined).
- Write 0x55 to A=7, read A=7 on the next cycle -> Q=0x55.
- Assert RSTB low while a read is in flight at READ_LATENCY=2 -> no QV, Q=0, INIT_DONE=0; init re-runs for 256 cycles.
- WORD_DEPTH=200: write A=210, then read A=210 -> Q=0, QV=1; read A=199 still returns its prior data.
